decode_pipe_stage: RTL

Parametrised decode stage: register file, immediate generation, load-use hazard detection and an output pipeline register.
- Fetch side: valid/ready handshake. Execute side: valid/ready handshake. Writeback port from the WB stage.
- Adds stall, flush, a configurable register count/width and an optional same-cycle writeback bypass.

---
 rtl/decode_pipe_stage_pkg.sv | 70 +++++++
 rtl/decode_pipe_stage_reg_file_param.sv | 77 +++++++
 rtl/decode_pipe_stage.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/decode_pipe_stage_pkg.sv
// ----------------------------------------------------------------------------
// decode_pipe_stage_pkg
// Shared types and helpers for the decode stage:
//   opcode_e     - RV32 base opcodes the stage understands
//   instr_t      - field view of a 32-bit instruction word
//   dec_ctrl_t   - control part of the decoded bundle
//   imm_gen()    - sign-extended immediate (64 bits; callers truncate to XLEN)
//   decode_ctrl()- destination index and write/load flags of an instruction
// ----------------------------------------------------------------------------
package decode_pipe_stage_pkg;

    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_IMM    = 7'b0010011,
        OP_REG    = 7'b0110011
    } opcode_e;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } instr_t;

    typedef struct packed {
        logic [4:0] rd;
        logic       writes_rd;  // opcode class writes a register (rd==0 filtered later)
        logic       is_load;
    } dec_ctrl_t;

    // Widest supported datapath; imm_gen builds at this width so any XLEN
    // can take the low bits and still see a correct sign extension.
    localparam int IMM_W = 64;

    function automatic logic [IMM_W-1:0] imm_gen(input instr_t instr);
        logic [31:0]      w;
        logic [IMM_W-1:0] imm;
        w = instr;
        case (instr.opcode)
            OP_IMM, OP_LOAD, OP_JALR: imm = {{52{w[31]}}, w[31:20]};
            OP_STORE:                 imm = {{52{w[31]}}, w[31:25], w[11:7]};
            OP_BRANCH:                imm = {{51{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            OP_LUI, OP_AUIPC:         imm = {{32{w[31]}}, w[31:12], 12'h000};
            OP_JAL:                   imm = {{43{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default:                  imm = {IMM_W{1'b0}};
        endcase
        return imm;
    endfunction

    function automatic dec_ctrl_t decode_ctrl(input instr_t instr);
        dec_ctrl_t c;
        c.rd      = instr.rd;
        c.is_load = (instr.opcode == OP_LOAD);
        case (instr.opcode)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
            OP_LOAD, OP_IMM, OP_REG: c.writes_rd = 1'b1;
            default:                 c.writes_rd = 1'b0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/decode_pipe_stage_reg_file_param.sv
// ----------------------------------------------------------------------------
// reg_file_param
// NUM_REGS x XLEN register file, two combinational read ports, one write port.
// Index 0 is hardwired to zero and never written. Synchronous active-high
// reset clears every entry.
// Optional macro DECODE_WB_BYPASS_EN: a read of the index being written this
// cycle returns the write data (write-first); otherwise reads see the stored
// value (read-first).
// Ports:
//   clk, reset                      clock, synchronous reset
//   wr_en_i, wr_id_i, wr_data_i     write port
//   rd1_id_i/rd1_data_o             read port 1
//   rd2_id_i/rd2_data_o             read port 2
// ----------------------------------------------------------------------------
module reg_file_param #(
    parameter  int XLEN     = 32,
    parameter  int NUM_REGS = 32,
    localparam int REG_ID_W = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en_i,
    input  logic [REG_ID_W-1:0] wr_id_i,
    input  logic [XLEN-1:0]     wr_data_i,
    input  logic [REG_ID_W-1:0] rd1_id_i,
    output logic [XLEN-1:0]     rd1_data_o,
    input  logic [REG_ID_W-1:0] rd2_id_i,
    output logic [XLEN-1:0]     rd2_data_o
);

    logic [XLEN-1:0] regs_q [NUM_REGS];
    logic            wr_live_s;

    assign wr_live_s = wr_en_i && (wr_id_i != {REG_ID_W{1'b0}});

    // Storage update: clear on reset, otherwise perform the write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= {XLEN{1'b0}};
            end
        end else if (wr_live_s) begin
            regs_q[wr_id_i] <= wr_data_i;
        end else begin
            regs_q[0] <= regs_q[0];
        end
    end

    // Read port 1.
    always_comb begin
        rd1_data_o = {XLEN{1'b0}};
        if (rd1_id_i == {REG_ID_W{1'b0}}) begin
            rd1_data_o = {XLEN{1'b0}};
`ifdef DECODE_WB_BYPASS_EN
        end else if (wr_live_s && (wr_id_i == rd1_id_i)) begin
            rd1_data_o = wr_data_i;
`endif
        end else begin
            rd1_data_o = regs_q[rd1_id_i];
        end
    end

    // Read port 2.
    always_comb begin
        rd2_data_o = {XLEN{1'b0}};
        if (rd2_id_i == {REG_ID_W{1'b0}}) begin
            rd2_data_o = {XLEN{1'b0}};
`ifdef DECODE_WB_BYPASS_EN
        end else if (wr_live_s && (wr_id_i == rd2_id_i)) begin
            rd2_data_o = wr_data_i;
`endif
        end else begin
            rd2_data_o = regs_q[rd2_id_i];
        end
    end

endmodule

// File: rtl/decode_pipe_stage.sv
// ----------------------------------------------------------------------------
// decode_pipe_stage
// Decode stage: register-file read, immediate generation, load-use hazard
// detection and a single output pipeline register with valid/ready on both
// sides. Optional macro DECODE_WB_BYPASS_EN selects write-first operand
// reads in the register file.
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   in_valid/in_ready/in_instr/in_pc   fetch handshake (in_ready combinational)
//   flush                              drop the held and incoming instruction
//   wb_en/wb_id/wb_data                register-file write from writeback
//   out_valid/out_ready                execute handshake
//   out_pc, out_rs1_data, out_rs2_data, out_imm, out_rd,
//   out_is_write_back, out_is_load     registered decoded bundle
// ----------------------------------------------------------------------------
module decode_pipe_stage
    import decode_pipe_stage_pkg::*;
#(
    parameter  int XLEN     = 32,
    parameter  int NUM_REGS = 32,
    localparam int REG_ID_W = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_instr,
    input  logic [XLEN-1:0]     in_pc,
    input  logic                flush,
    input  logic                wb_en,
    input  logic [REG_ID_W-1:0] wb_id,
    input  logic [XLEN-1:0]     wb_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_pc,
    output logic [XLEN-1:0]     out_rs1_data,
    output logic [XLEN-1:0]     out_rs2_data,
    output logic [XLEN-1:0]     out_imm,
    output logic [REG_ID_W-1:0] out_rd,
    output logic                out_is_write_back,
    output logic                out_is_load
);

    instr_t              ins_s;
    dec_ctrl_t           ctrl_s;
    logic [REG_ID_W-1:0] rs1_id_s;
    logic [REG_ID_W-1:0] rs2_id_s;
    logic [REG_ID_W-1:0] rd_id_s;
    logic [XLEN-1:0]     rs1_data_s;
    logic [XLEN-1:0]     rs2_data_s;
    logic [XLEN-1:0]     imm_s;
    logic                hazard_s;
    logic                accept_s;

    logic                out_valid_q, out_valid_d;
    logic [XLEN-1:0]     out_pc_q, out_pc_d;
    logic [XLEN-1:0]     out_rs1_q, out_rs1_d;
    logic [XLEN-1:0]     out_rs2_q, out_rs2_d;
    logic [XLEN-1:0]     out_imm_q, out_imm_d;
    logic [REG_ID_W-1:0] out_rd_q, out_rd_d;
    logic                out_wb_q, out_wb_d;
    logic                out_load_q, out_load_d;

    assign ins_s    = instr_t'(in_instr);
    assign ctrl_s   = decode_ctrl(ins_s);
    // RV32E keeps only the low index bits; upper bits are ignored, not trapped.
    assign rs1_id_s = ins_s.rs1[REG_ID_W-1:0];
    assign rs2_id_s = ins_s.rs2[REG_ID_W-1:0];
    assign rd_id_s  = ctrl_s.rd[REG_ID_W-1:0];
    assign imm_s    = XLEN'(imm_gen(ins_s));

    reg_file_param #(
        .XLEN     (XLEN),
        .NUM_REGS (NUM_REGS)
    ) u_reg_file (
        .clk        (clk),
        .reset      (reset),
        .wr_en_i    (wb_en),
        .wr_id_i    (wb_id),
        .wr_data_i  (wb_data),
        .rd1_id_i   (rs1_id_s),
        .rd1_data_o (rs1_data_s),
        .rd2_id_i   (rs2_id_s),
        .rd2_data_o (rs2_data_s)
    );

    // A load in the output register cannot forward its result yet, so any
    // consumer of its rd (either source field, whatever the format) waits.
    assign hazard_s = out_valid_q && out_load_q && (out_rd_q != {REG_ID_W{1'b0}}) &&
                      ((out_rd_q == rs1_id_s) || (out_rd_q == rs2_id_s));
    assign in_ready = !reset && !hazard_s && (!out_valid_q || out_ready);
    assign accept_s = in_valid && in_ready;

    // Next state of the output register: flush beats accept, accept beats drain.
    always_comb begin
        out_valid_d = out_valid_q;
        out_pc_d    = out_pc_q;
        out_rs1_d   = out_rs1_q;
        out_rs2_d   = out_rs2_q;
        out_imm_d   = out_imm_q;
        out_rd_d    = out_rd_q;
        out_wb_d    = out_wb_q;
        out_load_d  = out_load_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept_s) begin
            out_valid_d = 1'b1;
            out_pc_d    = in_pc;
            out_rs1_d   = rs1_data_s;
            out_rs2_d   = rs2_data_s;
            out_imm_d   = imm_s;
            out_rd_d    = rd_id_s;
            out_wb_d    = ctrl_s.writes_rd && (rd_id_s != {REG_ID_W{1'b0}});
            out_load_d  = ctrl_s.is_load;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Output pipeline register.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_pc_q    <= {XLEN{1'b0}};
            out_rs1_q   <= {XLEN{1'b0}};
            out_rs2_q   <= {XLEN{1'b0}};
            out_imm_q   <= {XLEN{1'b0}};
            out_rd_q    <= {REG_ID_W{1'b0}};
            out_wb_q    <= 1'b0;
            out_load_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            out_rs1_q   <= out_rs1_d;
            out_rs2_q   <= out_rs2_d;
            out_imm_q   <= out_imm_d;
            out_rd_q    <= out_rd_d;
            out_wb_q    <= out_wb_d;
            out_load_q  <= out_load_d;
        end
    end

    assign out_valid         = out_valid_q;
    assign out_pc            = out_pc_q;
    assign out_rs1_data      = out_rs1_q;
    assign out_rs2_data      = out_rs2_q;
    assign out_imm           = out_imm_q;
    assign out_rd            = out_rd_q;
    assign out_is_write_back = out_wb_q;
    assign out_is_load       = out_load_q;

endmodule
